// File: rtl/scariv_bru_pkg.sv
// Shared BRU scheduler constants: entry count and entry index type.
package scariv_bru_pkg;
  localparam int BRU_ENTRY_SIZE = 8;
  localparam int BRU_ENTRY_W    = $clog2(BRU_ENTRY_SIZE);
  typedef logic [BRU_ENTRY_W-1:0] bru_idx_t;
endpackage

// File: rtl/scariv_age_matrix_picker.sv
// Age matrix over the issue entries; selects the oldest ready entry, same cycle.
// Only entries with valid high take part, so ages left behind by freed entries never matter.
module scariv_age_matrix_picker #(
  parameter int ENTRY_SIZE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [ENTRY_SIZE-1:0] i_entry_valid,
  input  logic [ENTRY_SIZE-1:0] i_entry_ready,
  input  logic [ENTRY_SIZE-1:0] i_entry_put,
  output logic [ENTRY_SIZE-1:0] o_entry_picked
);
  logic [ENTRY_SIZE-1:0] r_age [ENTRY_SIZE];
  logic [ENTRY_SIZE-1:0] ready_eff;
  logic [ENTRY_SIZE-1:0] blocked;
  logic [ENTRY_SIZE-1:0] cand;

  // A new entry is younger than every entry currently occupied.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRY_SIZE; i++) r_age[i] <= '0;
    end else begin
      for (int k = 0; k < ENTRY_SIZE; k++) begin
        if (i_entry_put[k]) begin
          r_age[k] <= '0;
          for (int j = 0; j < ENTRY_SIZE; j++) begin
            if (j != k) r_age[j][k] <= i_entry_valid[j];
          end
        end
      end
    end
  end

  assign ready_eff = i_entry_ready & i_entry_valid;

  always_comb begin
    blocked = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      for (int j = 0; j < ENTRY_SIZE; j++) begin
        if (ready_eff[j] && r_age[j][i]) blocked[i] = 1'b1;
      end
    end
  end

  assign cand = ready_eff & ~blocked;

  scariv_bit_extract_lsb #(.WIDTH(ENTRY_SIZE)) u_pick_lsb (
    .in  (cand),
    .out (o_entry_picked)
  );
endmodule

// File: rtl/scariv_bit_extract_lsb.sv
// Isolates the lowest set bit of a vector (combinational priority select).
module scariv_bit_extract_lsb #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  assign out = in & (~in + {{(WIDTH-1){1'b0}}, 1'b1});
endmodule

// File: rtl/scariv_bru_sched_ctrl.sv
// BRU issue scheduler control: lowest-free allocation, oldest-ready pick, 1-cycle registered issue.
// Dispatch is held off (o_disp_ready low) only when every entry is occupied.
module scariv_bru_sched_ctrl
  import scariv_bru_pkg::*;
#(
  parameter int ENTRY_SIZE = BRU_ENTRY_SIZE
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_disp_valid,
  output logic                          o_disp_ready,
  output logic [ENTRY_SIZE-1:0]         o_entry_put,
  input  logic [ENTRY_SIZE-1:0]         i_entry_valid,
  input  logic [ENTRY_SIZE-1:0]         i_entry_ready,
  input  logic [ENTRY_SIZE-1:0]         i_entry_issue_succeeded,
  output logic [ENTRY_SIZE-1:0]         o_entry_picked,
  output logic [ENTRY_SIZE-1:0]         o_entry_clear,
  output logic                          o_issue_valid,
  output logic [$clog2(ENTRY_SIZE)-1:0] o_issue_index,
  output logic [$clog2(ENTRY_SIZE):0]   o_free_cnt
);
  localparam int IDX_W = $clog2(ENTRY_SIZE);

  logic [ENTRY_SIZE-1:0] free;
  logic [ENTRY_SIZE-1:0] free_lsb;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W:0]        free_cnt;

  assign free          = ~i_entry_valid;
  assign o_disp_ready  = |free;
  assign o_entry_clear = i_entry_issue_succeeded;

  scariv_bit_extract_lsb #(.WIDTH(ENTRY_SIZE)) u_free_lsb (
    .in  (free),
    .out (free_lsb)
  );

  assign o_entry_put = (i_disp_valid && o_disp_ready) ? free_lsb : '0;

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) free_cnt = free_cnt + {{IDX_W{1'b0}}, free[i]};
  end
  assign o_free_cnt = free_cnt;

  scariv_age_matrix_picker #(.ENTRY_SIZE(ENTRY_SIZE)) u_age_picker (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_entry_valid  (i_entry_valid),
    .i_entry_ready  (i_entry_ready),
    .i_entry_put    (o_entry_put),
    .o_entry_picked (o_entry_picked)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      if (o_entry_picked[i]) pick_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_issue_valid <= 1'b0;
      o_issue_index <= '0;
    end else begin
      o_issue_valid <= |o_entry_picked;
      o_issue_index <= pick_idx;
    end
  end
endmodule

// File: tb/tb_scariv_bru_sched_ctrl.sv
// Directed bench for scariv_bru_sched_ctrl; the bench itself plays the role of the entries.
module tb_scariv_bru_sched_ctrl;
  import scariv_bru_pkg::*;

  localparam int N = BRU_ENTRY_SIZE;

  logic                  clk;
  logic                  rst_n;
  logic                  disp_valid;
  logic                  disp_ready;
  logic [N-1:0]          entry_put;
  logic [N-1:0]          entry_valid;
  logic [N-1:0]          entry_ready;
  logic [N-1:0]          issue_succ;
  logic [N-1:0]          entry_picked;
  logic [N-1:0]          entry_clear;
  logic                  issue_valid;
  bru_idx_t              issue_index;
  logic [$clog2(N):0]    free_cnt;

  int vectors;
  int miscompares;

  scariv_bru_sched_ctrl #(.ENTRY_SIZE(N)) dut (
    .i_clk                   (clk),
    .i_reset_n               (rst_n),
    .i_disp_valid            (disp_valid),
    .o_disp_ready            (disp_ready),
    .o_entry_put             (entry_put),
    .i_entry_valid           (entry_valid),
    .i_entry_ready           (entry_ready),
    .i_entry_issue_succeeded (issue_succ),
    .o_entry_picked          (entry_picked),
    .o_entry_clear           (entry_clear),
    .o_issue_valid           (issue_valid),
    .o_issue_index           (issue_index),
    .o_free_cnt              (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    disp_valid  = 1'b1;
    entry_valid = '0;
    entry_ready = '0;
    issue_succ  = '0;

    // Reset: combinational outputs follow the idle entries
    #2;
    check("rst_put",       32'(entry_put),   32'h01);
    check("rst_ready",     32'(disp_ready),  32'h1);
    check("rst_free_cnt",  32'(free_cnt),    32'd8);
    check("rst_iss_vld",   32'(issue_valid), 32'h0);
    check("rst_iss_idx",   32'(issue_index), 32'h0);
    tick();
    rst_n = 1'b1;
    disp_valid = 1'b0;
    tick();

    // Puts land on 3, 1, 5 in that order; 0 and 2 are unready fillers
    disp_valid = 1'b1;
    entry_valid = 8'b0000_0111;
    #1 check("put3", 32'(entry_put), 32'h08);
    tick();
    entry_valid = 8'b0000_1101;
    #1 check("put1", 32'(entry_put), 32'h02);
    tick();
    entry_valid = 8'b0001_1111;
    #1 check("put5", 32'(entry_put), 32'h20);
    tick();
    disp_valid  = 1'b0;
    entry_valid = 8'b0011_1111;
    #1 check("no_put", 32'(entry_put), 32'h00);
    tick();
    entry_ready = 8'b0010_1010;
    #1 check("pick_oldest3", 32'(entry_picked), 32'h08);
    check("iss_vld_before", 32'(issue_valid), 32'h0);
    tick();
    check("iss_vld_3", 32'(issue_valid), 32'h1);
    check("iss_idx_3", 32'(issue_index), 32'd3);
    entry_ready = 8'b0010_0010;
    issue_succ  = 8'h08;
    #1 check("pick_next1", 32'(entry_picked), 32'h02);
    check("clear3", 32'(entry_clear), 32'h08);
    tick();
    issue_succ  = '0;
    entry_ready = '0;
    entry_valid = 8'b0011_0111;
    check("iss_idx_1", 32'(issue_index), 32'd1);
    #1 check("pick_none", 32'(entry_picked), 32'h00);
    tick();
    check("iss_vld_idle", 32'(issue_valid), 32'h0);

    // Full: dispatch stalls until a cleared entry's valid drops
    entry_valid = 8'hFF;
    disp_valid  = 1'b1;
    issue_succ  = 8'h40;
    #1 check("full_ready", 32'(disp_ready), 32'h0);
    check("full_put",      32'(entry_put),   32'h00);
    check("full_free_cnt", 32'(free_cnt),    32'd0);
    check("clear6",        32'(entry_clear), 32'h40);
    tick();
    issue_succ = '0;
    #1 check("full_put_hold", 32'(entry_put), 32'h00);
    tick();
    entry_valid = 8'hBF;
    #1 check("put6", 32'(entry_put), 32'h40);
    check("free_cnt_1", 32'(free_cnt), 32'd1);
    tick();

    // Put and two clears in one cycle
    entry_valid = 8'b0001_0011;
    issue_succ  = 8'b0001_0001;
    #1 check("put2_w_clear", 32'(entry_put),   32'h04);
    check("clear_0_4",       32'(entry_clear), 32'h11);
    check("free_cnt_5",      32'(free_cnt),    32'd5);
    tick();
    disp_valid  = 1'b0;
    issue_succ  = '0;
    entry_valid = 8'b0000_0110;
    #1 check("free_cnt_6", 32'(free_cnt), 32'd6);
    tick();

    // Age beats index: 0 older than 7
    disp_valid  = 1'b1;
    entry_valid = 8'h00;
    #1 check("put0", 32'(entry_put), 32'h01);
    tick();
    entry_valid = 8'h7F;
    #1 check("put7", 32'(entry_put), 32'h80);
    tick();
    disp_valid  = 1'b0;
    entry_valid = 8'hFF;
    entry_ready = 8'h80;
    #1 check("pick7_only", 32'(entry_picked), 32'h80);
    tick();
    check("iss_idx_7", 32'(issue_index), 32'd7);
    entry_ready = 8'h81;
    #1 check("pick0_older", 32'(entry_picked), 32'h01);
    tick();
    check("iss_vld_0", 32'(issue_valid), 32'h1);
    check("iss_idx_0", 32'(issue_index), 32'd0);

    // Asynchronous reset while an issue is pending
    rst_n       = 1'b0;
    entry_valid = '0;
    entry_ready = '0;
    #1 check("arst_iss_vld", 32'(issue_valid), 32'h0);
    check("arst_iss_idx",  32'(issue_index), 32'h0);
    check("arst_ready",    32'(disp_ready),  32'h1);
    check("arst_free_cnt", 32'(free_cnt),    32'd8);
    tick();
    rst_n = 1'b1;
    tick();
    entry_valid = 8'b0000_1100;
    entry_ready = 8'b0000_1100;
    #1 check("post_rst_pick", 32'(entry_picked), 32'h04);
    tick();
    check("post_rst_iss_vld", 32'(issue_valid), 32'h1);
    check("post_rst_iss_idx", 32'(issue_index), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/scariv_bru_sched_ctrl.md
SCARIV_BRU_SCHED_CTRL -- requirements
Module: scariv_bru_sched_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_SIZE, default 8, number of BRU issue entries controlled (power of 2, 2..32).
REQ-002 SHALL have i_clk input 1; clock, all state updates on rising edge.
REQ-003 SHALL have i_reset_n input 1; reset, asynchronous, active-low.
REQ-004 SHALL have i_disp_valid input 1; dispatch requests one BRU instruction this cycle.
REQ-005 SHALL have o_disp_ready output 1; at least one entry is free.
REQ-006 SHALL have o_entry_put output ENTRY_SIZE; one-hot put strobe to the allocated entry.
REQ-007 SHALL have i_entry_valid input ENTRY_SIZE; per-entry occupied flag from the entries.
REQ-008 SHALL have i_entry_ready input ENTRY_SIZE; per-entry issue-eligible flag (WAIT with all operands ready).
REQ-009 SHALL have i_entry_issue_succeeded input ENTRY_SIZE; per-entry SCHED_CLEAR indication.
REQ-010 SHALL have o_entry_picked output ENTRY_SIZE; one-hot pick strobe.
REQ-011 SHALL have o_entry_clear output ENTRY_SIZE; per-entry clear strobe.
REQ-012 SHALL have o_issue_valid output 1; registered issue to BRU pipe.
REQ-013 SHALL have o_issue_index output $clog2(ENTRY_SIZE); index of the issued entry.
REQ-014 SHALL have o_free_cnt output $clog2(ENTRY_SIZE)+1; count of entries with i_entry_valid low.

Function
REQ-015 Free vector SHALL be ~i_entry_valid; o_disp_ready SHALL be |free, combinational.
REQ-016 Allocation SHALL pick the lowest-index free entry; o_entry_put SHALL be that one-hot only when i_disp_valid & o_disp_ready, else all zero.
REQ-017 Dispatch with o_disp_ready low SHALL be ignored (no put, no state change); upstream holds the request.
REQ-018 Age matrix r_age[i][j] (1 = i older than j) SHALL update on put to k: r_age[k][*] <= 0, r_age[j][k] <= i_entry_valid[j] for all j != k.
REQ-019 Entry i SHALL be selected when i_entry_ready[i] and no j with i_entry_ready[j] & r_age[j][i]; o_entry_picked SHALL be that one-hot, zero if none ready, combinational, same cycle.
REQ-020 Among ready entries with no age relation (same-cycle ties impossible after REQ-018), the lowest index SHALL win.
REQ-021 On a pick, o_issue_valid SHALL assert the next cycle with o_issue_index = picked index; latency 1 cycle; no pick, o_issue_valid low next cycle.
REQ-022 o_entry_clear SHALL equal i_entry_issue_succeeded, combinational; any number of clears per cycle allowed.
REQ-023 A cleared entry SHALL become allocatable only after its i_entry_valid drops (earliest one cycle after clear).
REQ-024 Put and clear of different entries in the same cycle SHALL both take effect; put never targets an entry with valid high.
REQ-025 Ages of entries with valid low SHALL be don't-care and never affect picking.
REQ-026 o_free_cnt SHALL be popcount(~i_entry_valid), combinational, range 0..ENTRY_SIZE.
REQ-027 A pick of an entry that later re-enters WAIT (speculative-wakeup cancel) SHALL need no action here; the entry re-raises ready and is repicked by age.

Reset
REQ-028 On i_reset_n low, r_age SHALL clear to all zero, o_issue_valid to 0, o_issue_index to 0, asynchronously.
REQ-029 During reset, combinational outputs SHALL follow inputs; the reset entries hold valid low, so o_disp_ready=1 and o_free_cnt=ENTRY_SIZE.
REQ-030 Reset mid-operation SHALL drop any pending o_issue_valid with no residual age state.

Structure
REQ-031 Entry-count constant and index typedef SHALL reside in scariv_bru_pkg; the module SHALL contain no other package-level types.
REQ-032 The age matrix with its update and oldest-select logic SHALL be one sub-module, scariv_age_matrix_picker, parameterized by ENTRY_SIZE.
REQ-033 Lowest-index free select SHALL reuse the codebase's existing priority-encoder/bit-extract utility.

Verification
REQ-034 Reset, ENTRY_SIZE=8, all valid low, i_disp_valid=1 -> o_entry_put=8'h01, o_disp_ready=1, o_free_cnt=8.
REQ-035 Put entries 3,1,5 in that order on cycles 0,1,2, all ready in cycle 4 -> o_entry_picked=8'h08, cycle 5 o_issue_valid=1, o_issue_index=3.
REQ-036 All 8 valid, i_disp_valid=1 -> o_disp_ready=0, o_entry_put=0; clear entry 6 -> put targets 6 one cycle after valid drops.
REQ-037 Same cycle: put to entry 2, clears on entries 0 and 4 -> put=8'h04, clear=8'h11, next cycle o_free_cnt reflects both.
REQ-038 Entry 0 (older) not ready, entry 7 ready -> picked=8'h80; entry 0 turns ready next cycle alongside 7 -> picked=8'h01.
REQ-039 Assert i_reset_n low while o_issue_valid=1 -> o_issue_valid=0 immediately; after release, first ready entry picks by index.
